mips_pipeline_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS64 core. It consumes hazard and decode status (decoder `except`, jump/ERET decode, EX load/branch status, data-memory handshake, CP0 EXL/irq).
- It produces per-stage stall/bubble/flush controls, the PC source select and the CP0 exception/ERET commit pulses.
- A 4-state FSM sequences multi-cycle data-memory waits (with bus-error timeout), exception entry and ERET return.

---
 rtl/mips_pipeline_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mips_pipeline_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS64 core.
// It turns hazard and decode status into per-stage stall, bubble and flush
// controls, the PC source select, and the CP0 exception and ERET commit pulses.
// A 4-state FSM handles multi-cycle data-memory waits, which raise a bus error
// on timeout, and one-cycle exception-entry and ERET-return sequences.
//
// Handshake: the data memory completes an access in any cycle where
// mem_req & mem_ready are both high. While the FSM waits, the MEM stage and
// everything upstream are held, and nothing retires into MEM/WB.
module mips_pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic       id_except,
  input  logic       id_eret,
  input  logic       id_jump,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       irq,
  input  logic       exl,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_if,
  output logic       bubble_ex,
  output logic       stall_mem,
  output logic       kill_mem,
  output logic [1:0] pc_sel,
  output logic       exc_take,
  output logic [4:0] exc_code,
  output logic       eret_take,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_EXC      = 2'd2,
    S_ERET     = 2'd3
  } state_t;

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_DBE = 5'd7;
  localparam logic [4:0] CODE_RI  = 5'd10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       exc_code_q;

  logic mem_stall;
  logic ri_req;
  logic exc_req;
  logic eret_req;
  logic load_use;

  // RUN-state hazard terms. A $zero destination never creates a dependency.
  assign mem_stall = mem_req & ~mem_ready;
  assign ri_req    = id_valid & id_except;
  assign exc_req   = ri_req | (irq & ~exl);
  assign eret_req  = id_valid & id_eret;
  assign load_use  = ex_load & (ex_rd != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_rd)) |
                      (id_uses_rt & (id_rt == ex_rd)));

  // FSM: state, wait counter and latched exception code.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      exc_code_q <= CODE_INT;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_stall) begin
            state_q <= S_MEM_WAIT;
            cnt_q   <= CNT_W'(1);
          end else if (ex_branch_taken) begin
            // The ID instruction is wrong-path; its requests are dropped.
            state_q <= S_RUN;
          end else if (exc_req) begin
            exc_code_q <= ri_req ? CODE_RI : CODE_INT;
            state_q    <= S_EXC;
          end else if (eret_req) begin
            state_q <= S_ERET;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            exc_code_q <= CODE_DBE;
            state_q    <= S_EXC;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EXC:   state_q <= S_RUN;
        S_ERET:  state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Combinational control decode from state, registers and hazard inputs.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_if  = 1'b0;
    bubble_ex = 1'b0;
    stall_mem = 1'b0;
    kill_mem  = 1'b0;
    pc_sel    = 2'b00;
    exc_take  = 1'b0;
    exc_code  = 5'd0;
    eret_take = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_RUN: begin
          if (mem_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_mem = 1'b1;
          end else if (ex_branch_taken) begin
            flush_if  = 1'b1;
            bubble_ex = 1'b1;
          end else if (exc_req || eret_req) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
          end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (id_jump) begin
            flush_if = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          // The completing cycle releases the pipeline immediately.
          if (!mem_ready) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_mem = 1'b1;
          end
        end
        S_EXC: begin
          exc_take  = 1'b1;
          exc_code  = exc_code_q;
          pc_sel    = 2'b01;
          flush_if  = 1'b1;
          bubble_ex = 1'b1;
          // A bus error must not let the faulting access retire.
          kill_mem  = (exc_code_q == CODE_DBE);
        end
        S_ERET: begin
          eret_take = 1'b1;
          pc_sel    = 2'b10;
          flush_if  = 1'b1;
          bubble_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = reset_n ? state_q : S_RUN;

endmodule

// File: tb/tb_mips_pipeline_ctrl.sv
// Directed bench for mips_pipeline_ctrl with hand-computed control vectors.
module tb_mips_pipeline_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       id_valid, id_except, id_eret, id_jump;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic       ex_load;
  logic [4:0] ex_rd;
  logic       ex_branch_taken, mem_req, mem_ready, irq, exl;
  logic       stall_if, stall_id, flush_if, bubble_ex, stall_mem, kill_mem;
  logic [1:0] pc_sel;
  logic       exc_take;
  logic [4:0] exc_code;
  logic       eret_take;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] ctl;
  logic [16:0] exp_v;

  mips_pipeline_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_except(id_except), .id_eret(id_eret), .id_jump(id_jump),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_load(ex_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .irq(irq), .exl(exl),
    .stall_if(stall_if), .stall_id(stall_id), .flush_if(flush_if), .bubble_ex(bubble_ex),
    .stall_mem(stall_mem), .kill_mem(kill_mem), .pc_sel(pc_sel), .exc_take(exc_take),
    .exc_code(exc_code), .eret_take(eret_take), .state(state)
  );

  // Clock generation.
  always #5 clock = ~clock;

  assign ctl = {stall_if, stall_id, flush_if, bubble_ex, stall_mem, kill_mem,
                pc_sel, exc_take, exc_code, eret_take, state};

  // Packs an expected control vector in the same order as ctl.
  function automatic logic [16:0] ev(input logic si, input logic sd, input logic fi,
                                     input logic bx, input logic sm, input logic km,
                                     input logic [1:0] pc, input logic et,
                                     input logic [4:0] ec, input logic er,
                                     input logic [1:0] st);
    return {si, sd, fi, bx, sm, km, pc, et, ec, er, st};
  endfunction

  task automatic clear_in();
    id_valid = 0; id_except = 0; id_eret = 0; id_jump = 0;
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_load = 0; ex_rd = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0; irq = 0; exl = 0;
  endtask

  // Advance one clock, landing 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_in();
    id_valid = 1; id_except = 1; mem_req = 1; irq = 1;
    tick();
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h exp %h", ctl, exp_v); end
    clear_in();
    reset_n = 1;
    tick();
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL reset_release: got %h exp %h", ctl, exp_v); end
  endtask

  task automatic test_load_use();
    clear_in();
    id_valid = 1; ex_load = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    #1;
    exp_v = ev(1,1,0,1,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL lu_rs_hit: got %h exp %h", ctl, exp_v); end
    tick();
    // Next cycle EX holds the bubble, so no dependency remains.
    ex_load = 0;
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL lu_one_cycle: got %h exp %h", ctl, exp_v); end
    tick();
    ex_load = 1; ex_rd = 0; id_rs = 0;
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL lu_zero_rd: got %h exp %h", ctl, exp_v); end
    tick();
    ex_rd = 9; id_rt = 9; id_uses_rs = 0; id_uses_rt = 1; id_rs = 3;
    #1;
    exp_v = ev(1,1,0,1,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL lu_rt_hit: got %h exp %h", ctl, exp_v); end
    tick();
    id_uses_rt = 0;
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL lu_unused_src: got %h exp %h", ctl, exp_v); end
    tick();
    clear_in();
    id_valid = 1; id_jump = 1;
    #1;
    exp_v = ev(0,0,1,0,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL jump_flush: got %h exp %h", ctl, exp_v); end
    tick();
    clear_in();
  endtask

  task automatic test_mem_wait();
    clear_in();
    mem_req = 1; mem_ready = 0;
    #1;
    exp_v = ev(1,1,0,0,1,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL mw_detect: got %h exp %h", ctl, exp_v); end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_v = ev(1,1,0,0,1,0,2'b00,0,5'd0,0,2'd1); n_cmp++;
      if (ctl !== exp_v) begin n_err++; $display("FAIL mw_wait%0d: got %h exp %h", i, ctl, exp_v); end
      tick();
    end
    mem_ready = 1;
    #1;
    exp_v = ev(0,0,0,0,0,0,2'b00,0,5'd0,0,2'd1); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL mw_ready: got %h exp %h", ctl, exp_v); end
    tick();
    clear_in();
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL mw_back_run: got %h exp %h", ctl, exp_v); end
    tick();
  endtask

  // Runs a full timeout starting in RUN: detect, 16 waiting cycles, then DBE.
  task automatic test_timeout(input string tag);
    clear_in();
    mem_req = 1; mem_ready = 0;
    #1;
    exp_v = ev(1,1,0,0,1,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL %s_detect: got %h exp %h", tag, ctl, exp_v); end
    tick();
    for (int i = 1; i <= 16; i++) begin
      #1;
      exp_v = ev(1,1,0,0,1,0,2'b00,0,5'd0,0,2'd1); n_cmp++;
      if (ctl !== exp_v) begin n_err++; $display("FAIL %s_wait%0d: got %h exp %h", tag, i, ctl, exp_v); end
      tick();
    end
    clear_in();
    #1;
    exp_v = ev(0,0,1,1,0,1,2'b01,1,5'd7,0,2'd2); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL %s_dbe: got %h exp %h", tag, ctl, exp_v); end
    tick();
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL %s_after: got %h exp %h", tag, ctl, exp_v); end
  endtask

  task automatic test_ri_vs_branch();
    clear_in();
    id_valid = 1; id_except = 1; irq = 1; exl = 0;
    #1;
    exp_v = ev(1,0,0,1,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL ri_detect: got %h exp %h", ctl, exp_v); end
    tick();
    clear_in();
    #1;
    exp_v = ev(0,0,1,1,0,0,2'b01,1,5'd10,0,2'd2); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL ri_take: got %h exp %h", ctl, exp_v); end
    tick();
    id_valid = 1; id_except = 1; ex_branch_taken = 1;
    #1;
    exp_v = ev(0,0,1,1,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL ri_branch: got %h exp %h", ctl, exp_v); end
    tick();
    clear_in();
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL ri_branch_next: got %h exp %h", ctl, exp_v); end
    tick();
  endtask

  task automatic test_irq_eret();
    clear_in();
    irq = 1; exl = 1;
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL irq_masked: got %h exp %h", ctl, exp_v); end
    tick();
    exl = 0;
    #1;
    exp_v = ev(1,0,0,1,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL irq_detect: got %h exp %h", ctl, exp_v); end
    tick();
    irq = 1; exl = 1;
    #1;
    exp_v = ev(0,0,1,1,0,0,2'b01,1,5'd0,0,2'd2); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL irq_take: got %h exp %h", ctl, exp_v); end
    tick();
    id_valid = 1; id_eret = 1;
    #1;
    exp_v = ev(1,0,0,1,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL eret_detect: got %h exp %h", ctl, exp_v); end
    tick();
    clear_in();
    #1;
    exp_v = ev(0,0,1,1,0,0,2'b10,0,5'd0,1,2'd3); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL eret_take: got %h exp %h", ctl, exp_v); end
    tick();
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL eret_after: got %h exp %h", ctl, exp_v); end
    tick();
  endtask

  // Exception with ERET pending in ID: EXC is followed by a RUN cycle before ERET.
  task automatic test_back_to_back();
    clear_in();
    id_valid = 1; id_except = 1;
    tick();
    id_except = 0; id_eret = 1;
    #1;
    exp_v = ev(0,0,1,1,0,0,2'b01,1,5'd10,0,2'd2); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL b2b_exc: got %h exp %h", ctl, exp_v); end
    tick();
    #1;
    exp_v = ev(1,0,0,1,0,0,2'b00,0,5'd0,0,2'd0); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL b2b_run_gap: got %h exp %h", ctl, exp_v); end
    tick();
    clear_in();
    #1;
    exp_v = ev(0,0,1,1,0,0,2'b10,0,5'd0,1,2'd3); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL b2b_eret: got %h exp %h", ctl, exp_v); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    clear_in();
    mem_req = 1; mem_ready = 0;
    tick();
    // MEM_WAIT entered with cnt=1; six more waits bring it to 7.
    for (int i = 0; i < 6; i++) tick();
    #1;
    exp_v = ev(1,1,0,0,1,0,2'b00,0,5'd0,0,2'd1); n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL rmw_waiting: got %h exp %h", ctl, exp_v); end
    reset_n = 0;
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL rmw_forced0: got %h exp %h", ctl, exp_v); end
    tick();
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL rmw_in_reset: got %h exp %h", ctl, exp_v); end
    clear_in();
    reset_n = 1;
    #1;
    exp_v = '0; n_cmp++;
    if (ctl !== exp_v) begin n_err++; $display("FAIL rmw_released: got %h exp %h", ctl, exp_v); end
    tick();
    test_timeout("rmw_fresh");
    tick();
  endtask

  initial begin
    clear_in();
    reset_n = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout("tmo");
    tick();
    test_ri_vs_branch();
    test_irq_eret();
    test_back_to_back();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
